// File: rtl/cordic_sched_pkg.sv
// rtl/cordic_sched_pkg.sv - shared types and arbitration helper for the CORDIC stream scheduler
package cordic_sched_pkg;

  typedef enum logic {IDLE, LOCKED} sched_state_t;

  localparam int CORDIC_LATENCY = 15;

  // Round-robin pick: first set bit of req after ptr, modulo num_ch (up to 8 channels).
  function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] ptr,
                                         input int num_ch);
    logic [2:0] sel;
    logic       found;
    int         idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= num_ch && !found) begin
        idx = (int'(ptr) + i) % num_ch;
        if (req[idx[2:0]]) begin
          sel   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/cordic_stream_scheduler_tag_fifo.sv
// rtl/cordic_stream_scheduler_tag_fifo.sv - channel-tag FIFO tracking beats in flight through the CORDIC
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_stream_scheduler.sv
// rtl/cordic_stream_scheduler.sv - round-robin sharing of one CORDIC pipeline across IQ streams
module cordic_stream_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int DATA_W        = 32,
  parameter int TAG_DEPTH     = 32,
  parameter bit LOCK_ON_TLAST = 1'b1
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [DATA_W-1:0]        cor_s_tdata,
  output logic                     cor_s_tvalid,
  output logic                     cor_s_tlast,
  output logic [DATA_W/8-1:0]      cor_s_tstrb,
  input  logic                     cor_s_tready,
  input  logic [DATA_W-1:0]        cor_m_tdata,
  input  logic                     cor_m_tvalid,
  input  logic                     cor_m_tlast,
  output logic                     cor_m_tready,
  output logic [DATA_W-1:0]        m00_axis_tdata,
  output logic                     m00_axis_tvalid,
  output logic                     m00_axis_tlast,
  output logic [CH_W-1:0]          m00_axis_tuser,
  input  logic                     m00_axis_tready,
  output logic                     tag_err
);

  sched_state_t    state, state_n;
  logic [CH_W-1:0] grant, grant_n;
  logic [CH_W-1:0] rr_ptr, rr_n;
  logic [7:0]      req_ext;
  logic [2:0]      pick;
  logic            cur_valid;
  logic            cur_last;
  logic            accept;
  logic            tag_full;
  logic            tag_empty;
  logic            tag_pop;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_CH-1:0] = s_tvalid & ch_enable;
  end

  assign pick      = next_rr(req_ext, 3'(rr_ptr), NUM_CH);
  assign cur_valid = s_tvalid[grant];
  assign cur_last  = s_tlast[grant];

  assign cor_s_tdata  = s_tdata[grant*DATA_W +: DATA_W];
  assign cor_s_tlast  = cur_last;
  assign cor_s_tstrb  = '1;
  assign cor_s_tvalid = (state == LOCKED) & cur_valid & ~tag_full;
  assign accept       = cor_s_tvalid & cor_s_tready;

  // Downstream ready is the single stall path; the CORDIC advances only with it.
  assign cor_m_tready    = m00_axis_tready;
  assign m00_axis_tdata  = cor_m_tdata;
  assign m00_axis_tvalid = cor_m_tvalid;
  assign m00_axis_tlast  = cor_m_tlast;
  assign tag_pop         = m00_axis_tvalid & m00_axis_tready;

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    rr_n     = rr_ptr;
    s_tready = '0;
    case (state)
      IDLE: begin
        if (|req_ext) begin
          grant_n = CH_W'(pick);
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        s_tready[grant] = cor_s_tready & ~tag_full;
        if (accept && (cur_last || !LOCK_ON_TLAST)) begin
          rr_n    = grant;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_n;
    end
  end

  // Sticky: a result with no tag means the tag/beat pairing is lost until reset.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      tag_err <= 1'b0;
    end else if (tag_pop && tag_empty) begin
      tag_err <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .push  (accept),
    .pop   (tag_pop),
    .din   (grant),
    .dout  (m00_axis_tuser),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_cordic_stream_scheduler.sv
// tb/tb_cordic_stream_scheduler.sv - scoreboard bench for cordic_stream_scheduler with a CORDIC pipeline stand-in
module tb_cordic_stream_scheduler;

  localparam int NCH = 4;
  localparam int LAT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [127:0]  s_tdata = '0;
  logic [3:0]    s_tvalid = '0;
  logic [3:0]    s_tlast = '0;
  logic [3:0]    s_tready;
  logic [3:0]    ch_enable = 4'b1111;
  logic [31:0]   cor_s_tdata;
  logic          cor_s_tvalid;
  logic          cor_s_tlast;
  logic [3:0]    cor_s_tstrb;
  logic          cor_s_tready;
  logic [31:0]   cor_m_tdata = '0;
  logic          cor_m_tvalid = 1'b0;
  logic          cor_m_tlast = 1'b0;
  logic          cor_m_tready;
  logic [31:0]   m00_axis_tdata;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic [1:0]    m00_axis_tuser;
  logic          m00_axis_tready = 1'b1;
  logic          tag_err;

  assign cor_s_tready = cor_m_tready;

  always #5 clk = ~clk;

  cordic_stream_scheduler dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s_tdata          (s_tdata),
    .s_tvalid         (s_tvalid),
    .s_tlast          (s_tlast),
    .s_tready         (s_tready),
    .ch_enable        (ch_enable),
    .cor_s_tdata      (cor_s_tdata),
    .cor_s_tvalid     (cor_s_tvalid),
    .cor_s_tlast      (cor_s_tlast),
    .cor_s_tstrb      (cor_s_tstrb),
    .cor_s_tready     (cor_s_tready),
    .cor_m_tdata      (cor_m_tdata),
    .cor_m_tvalid     (cor_m_tvalid),
    .cor_m_tlast      (cor_m_tlast),
    .cor_m_tready     (cor_m_tready),
    .m00_axis_tdata   (m00_axis_tdata),
    .m00_axis_tvalid  (m00_axis_tvalid),
    .m00_axis_tlast   (m00_axis_tlast),
    .m00_axis_tuser   (m00_axis_tuser),
    .m00_axis_tready  (m00_axis_tready),
    .tag_err          (tag_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_ch = NCH - 1;

  logic [32:0] drv_q [NCH][$];
  logic [32:0] mdl_q [NCH][$];
  logic [34:0] sb [$];
  logic [33:0] pipe [LAT];
  logic [3:0]  mid = '0;
  logic [3:0]  en_req = 4'b1111;
  logic        rdy_rand = 1'b0;
  logic        stall_req = 1'b0;
  logic        force_v = 1'b0;
  logic        mon_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic add_pkt(input int c, input int len, input logic fixed_d, input logic [31:0] d);
    logic [31:0] v;
    for (int i = 0; i < len; i++) begin
      v = fixed_d ? d : $urandom;
      drv_q[c].push_back({(i == len - 1), v});
      mdl_q[c].push_back({(i == len - 1), v});
    end
  endtask

  // Packet-level round robin over the bench's pending packets.
  task automatic model_drain(input logic [3:0] mask);
    int          c;
    logic        found;
    logic [32:0] b;
    for (int guard = 0; guard < 500; guard++) begin
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= NCH; k++) begin
        int cc;
        cc = (last_ch + k) % NCH;
        if (!found && mask[cc] && mdl_q[cc].size() > 0) begin
          c = cc;
          found = 1'b1;
        end
      end
      if (!found) break;
      do begin
        b = mdl_q[c].pop_front();
        sb.push_back({b, 2'(c)});
      end while (!b[32]);
      last_ch = c;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk({name, "_drain_timeout"}, sb.size(), 0);
    repeat (25) @(posedge clk);
    #2;
    chk({name, "_tag_err"}, {31'd0, tag_err}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      drv_q[c].delete();
      mdl_q[c].delete();
    end
    sb.delete();
    mid = '0;
    s_tvalid = '0;
    s_tlast = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    cor_m_tvalid = 1'b0;
    cor_m_tlast = 1'b0;
    cor_m_tdata = '0;
    last_ch = NCH - 1;
    #1;
    chk("rst_s_tready", {28'd0, s_tready}, 0);
    chk("rst_cor_s_tvalid", {31'd0, cor_s_tvalid}, 0);
    chk("rst_m_tvalid", {31'd0, m00_axis_tvalid}, 0);
    chk("rst_tag_err", {31'd0, tag_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus drivers plus a 15-stage pipeline standing in for the CORDIC (data passes through).
  initial begin
    logic [3:0]  hs;
    logic        cs_acc, cs_l, adv;
    logic [31:0] cs_d;
    logic [32:0] b;
    int          stall_cnt;
    stall_cnt = 0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      cs_acc = cor_s_tvalid & cor_s_tready;
      cs_d = cor_s_tdata;
      cs_l = cor_s_tlast;
      adv = cor_m_tready;
      if (rst_n && cs_acc && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (hs[c] && drv_q[c].size() > 0) begin
            b = drv_q[c].pop_front();
            mid[c] = ~b[32];
            acc_cnt++;
          end
        end
        if (adv) begin
          for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
          pipe[0] = {cs_acc, cs_l, cs_d};
        end
      end
      if (stall_req) begin
        stall_cnt = 20;
        stall_req = 1'b0;
      end
      if (stall_cnt > 0) begin
        m00_axis_tready = 1'b0;
        stall_cnt--;
      end else begin
        m00_axis_tready = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin
        if (s_tvalid[c] && !hs[c] && drv_q[c].size() > 0) s_tvalid[c] = 1'b1;
        else if (drv_q[c].size() == 0) s_tvalid[c] = 1'b0;
        else if (mid[c]) s_tvalid[c] = ($urandom_range(0, 3) != 0);
        else s_tvalid[c] = 1'b1;
        if (drv_q[c].size() > 0) begin
          b = drv_q[c][0];
          s_tdata[c*32 +: 32] = b[31:0];
          s_tlast[c] = b[32];
        end else begin
          s_tdata[c*32 +: 32] = '0;
          s_tlast[c] = 1'b0;
        end
      end
      ch_enable = en_req;
      cor_m_tvalid = rst_n & (pipe[LAT-1][33] | force_v);
      cor_m_tlast = pipe[LAT-1][32];
      cor_m_tdata = pipe[LAT-1][31:0];
      force_v = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !mon_off) begin
        if (m00_axis_tvalid && m00_axis_tready) begin
          if (first_out < 0) first_out = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_beat", m00_axis_tdata, 32'hxxxx_xxxx);
          end else begin
            e = sb.pop_front();
            chk("out_tdata", m00_axis_tdata, e[33:2]);
            chk("out_tlast", {31'd0, m00_axis_tlast}, {31'd0, e[34]});
            chk("out_tuser", {30'd0, m00_axis_tuser}, {30'd0, e[1:0]});
          end
        end
        if (!m00_axis_tready) chk("stall_s_tready", {28'd0, s_tready}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    @(posedge clk);
    #2;
    do_reset();

    // Single channel, fixed I=0x1000 Q=0, latency from first accept to first output.
    @(posedge clk); #2;
    rdy_rand = 1'b0;
    add_pkt(0, 4, 1'b1, 32'h1000_0000);
    model_drain(4'b1111);
    wait_drain("single", 200);
    chk("latency", first_out - first_acc, LAT);

    // Round robin with two 2-beat packets per channel.
    @(posedge clk); #2;
    rdy_rand = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) add_pkt(c, 2, 1'b0, '0);
    model_drain(4'b1111);
    wait_drain("rr", 2000);

    // Random packet lengths with a 20-cycle downstream stall mid-stream.
    @(posedge clk); #2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCH; c++) add_pkt(c, $urandom_range(1, 5), 1'b0, '0);
    model_drain(4'b1111);
    repeat (30) @(posedge clk);
    #2;
    stall_req = 1'b1;
    wait_drain("stall", 4000);

    // Mask: ch2 requests but is disabled.
    @(posedge clk); #2;
    en_req = 4'b1011;
    for (int c = 0; c < NCH; c++) add_pkt(c, $urandom_range(1, 4), 1'b0, '0);
    model_drain(4'b1011);
    wait_drain("mask", 2000);

    // Clearing ch1's enable mid-packet lets that packet finish, then skips ch1.
    @(posedge clk); #2;
    add_pkt(1, 8, 1'b0, '0);
    model_drain(4'b1011);
    n = 0;
    while (!mid[1] && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (!mid[1]) chk("ch1_start_timeout", 0, 1);
    en_req = 4'b1001;
    add_pkt(1, 2, 1'b0, '0);
    add_pkt(3, 2, 1'b0, '0);
    model_drain(4'b1001);
    wait_drain("unmask_mid", 2000);
    @(posedge clk); #2;
    en_req = 4'b1111;
    model_drain(4'b1111);
    wait_drain("reenable", 2000);

    // Reset with beats in flight, then ch0 must win first arbitration.
    @(posedge clk); #2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCH; c++) add_pkt(c, 4, 1'b0, '0);
    n = acc_cnt;
    while (acc_cnt < n + 10 && acc_cnt < n + 1000) @(posedge clk);
    @(posedge clk); #2;
    do_reset();
    @(posedge clk); #2;
    chk("post_rst_m_tvalid", {31'd0, m00_axis_tvalid}, 0);
    for (int c = NCH - 1; c >= 0; c--) add_pkt(c, 3, 1'b0, '0);
    model_drain(4'b1111);
    wait_drain("post_rst", 2000);

    // Tag underflow: CORDIC output with no tag outstanding.
    @(posedge clk); #2;
    rdy_rand = 1'b0;
    mon_off = 1'b1;
    force_v = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("tag_err_set", {31'd0, tag_err}, 1);
    repeat (20) @(posedge clk);
    #2;
    chk("tag_err_sticky", {31'd0, tag_err}, 1);
    do_reset();
    mon_off = 1'b0;
    @(posedge clk); #2;
    chk("tag_err_cleared", {31'd0, tag_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_stream_scheduler.md
Name: cordic_stream_scheduler

Overview:
- Shares one 15-stage CORDIC rectangular-to-polar pipeline between NUM_CH IQ sample streams, e.g. the incident and reflected wave channels of each VNA port.
- Arbitrates round-robin at packet (tlast) granularity and tags every issued beat with its channel ID in a tag FIFO.
- Re-associates each CORDIC output beat with its channel and presents it on one output stream, with the channel ID on tuser.
- Sits between the per-channel decimator outputs and the polar-domain accumulators.

Parameters:
- NUM_CH, 4, number of requesting input streams (2..8).
- CH_W, 2, channel ID width; must satisfy 2**CH_W >= NUM_CH.
- DATA_W, 32, beat width ({I[31:16], Q[15:0]} in, {angle, radius} out).
- TAG_DEPTH, 32, tag FIFO depth; must be >= 16 (pipeline depth + 1); power of 2.
- LOCK_ON_TLAST, 1, 1 = hold grant until the granted channel's tlast beat; 0 = re-arbitrate after every beat.

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  async active-low reset
- s_tdata  in  NUM_CH*DATA_W  per-channel IQ beats, channel c at [c*DATA_W +: DATA_W]
- s_tvalid  in  NUM_CH  per-channel valid
- s_tlast  in  NUM_CH  per-channel end of packet
- s_tready  out  NUM_CH  per-channel ready
- ch_enable  in  NUM_CH  channel mask; a 0 bit excludes that channel from new grants
- cor_s_tdata  out  DATA_W  to CORDIC input
- cor_s_tvalid  out  1  to CORDIC input
- cor_s_tlast  out  1  to CORDIC input
- cor_s_tstrb  out  DATA_W/8  tied all-ones
- cor_s_tready  in  1  from CORDIC
- cor_m_tdata  in  DATA_W  from CORDIC output
- cor_m_tvalid  in  1  from CORDIC output
- cor_m_tlast  in  1  from CORDIC output
- cor_m_tready  out  1  to CORDIC output side (pipeline advance)
- m00_axis_tdata  out  DATA_W  polar result
- m00_axis_tvalid  out  1  result valid
- m00_axis_tlast  out  1  result end of packet
- m00_axis_tuser  out  CH_W  channel ID of the result
- m00_axis_tready  in  1  downstream ready
- tag_err  out  1  sticky: CORDIC output beat arrived while the tag FIFO was empty

Behaviour:
- Reset (async assert, sync deassert via clock):
  - state=IDLE, grant=0, rr_ptr=NUM_CH-1, tag FIFO empty, tag_err=0.
  - All outputs are 0 during reset: s_tready, cor_s_tvalid, m00_axis_tvalid.
  - The CORDIC shares this reset, so in-flight beats and tags are discarded together.
- Pipeline advance: cor_m_tready = m00_axis_tready, the only stall path. The CORDIC ready is combinational from this signal.
- IDLE state:
  - Candidates = s_tvalid & ch_enable.
  - Pick the first candidate searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - Register it in grant and go to LOCKED. This costs one bubble cycle. With no candidate, stay in IDLE.
- LOCKED state:
  - cor_s_tdata/tlast = s_tdata/s_tlast of channel grant.
  - cor_s_tvalid = s_tvalid[grant] & !tag_full.
  - s_tready[grant] = cor_s_tready & !tag_full; every other s_tready bit is 0.
  - Accepted beat = cor_s_tvalid & cor_s_tready. On each accepted beat, push grant into the tag FIFO.
  - LOCK_ON_TLAST=1: on an accepted beat with tlast, set rr_ptr<=grant and go to IDLE.
  - LOCK_ON_TLAST=0: do the same after every accepted beat.
  - Clearing ch_enable[grant] while LOCKED does not truncate: the packet completes, and the channel is excluded from the next arbitration.
- Output path:
  - m00_axis_tdata/tvalid/tlast = cor_m_*.
  - m00_axis_tuser = tag FIFO head.
  - Pop the FIFO on m00_axis_tvalid & m00_axis_tready.
- Tag FIFO:
  - Simultaneous push and pop leaves the count unchanged.
  - Push when full cannot occur, because issue is gated by tag_full.
  - Pop when empty sets tag_err, which stays set until reset; the count does not underflow.
  - Read and write pointers wrap modulo TAG_DEPTH.
- Latency: IDLE to first issue is 1 cycle. Issue to output is the CORDIC latency (15 pipeline advances). The scheduler adds no output register.
- Ordering: output order equals issue order; tags are FIFO-matched one beat to one tag.

Decomposition:
- Package cordic_sched_pkg:
  - sched_state_t enum {IDLE, LOCKED}.
  - CORDIC_LATENCY=15.
  - Function next_rr(req, ptr) returning the chosen channel.
- Sub-module tag_fifo:
  - Parameters: width CH_W, depth TAG_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Async reset.

Test Plan:
- Single channel: ch0 sends 4-beat packet, I=0x1000, Q=0x0000, m00_axis_tready=1 -> 4 outputs, angle=0 and radius≈0x1000; tuser=0 on all; tlast on the 4th; first output 15 cycles after first accept.
- Round-robin: all 4 channels hold 2-beat packets (LOCK_ON_TLAST=1) -> grant order 0,1,2,3,0; tuser sequence 0,0,1,1,2,2,3,3 at the output.
- Backpressure: m00_axis_tready low for 20 cycles mid-stream -> no output beat lost or duplicated; tuser stays aligned with data; s_tready[grant]=0 throughout the stall.
- Mask: ch_enable=4'b1011 with ch2 requesting -> ch2 never granted; clear ch_enable[1] mid-packet -> ch1 packet completes, then ch1 is skipped.
- Reset mid-packet: assert s00_axis_aresetn=0 with 10 beats in flight -> all outputs 0 immediately; after release the FIFO is empty, tag_err=0, and rr_ptr restarts so ch0 is granted first.
- Tag underflow: force cor_m_tvalid=1 with the FIFO empty -> tag_err=1, and it stays set until reset.
